receiver_uart: RTL and testbench

8N1 UART receiver, receive-side counterpart of the SOC's UART emitter. It brings `ftdi_rxd` into the clock domain through a two-flop synchronizer and samples each bit at mid-bit using a baud-rate divider. Received bytes go out through a valid/ready stream. The SOC maps that stream into the IO page: status bit 8 = `o_valid`, data read = pop.

---
 rtl/receiver_uart.sv | 224 ++++++++++++++++++++++
 tb/tb_receiver_uart.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver_uart.sv
// receiver_uart: 8N1 UART receiver with mid-bit sampling and a valid/ready byte stream.
// Optional build macro UART_RX_FIFO_EN selects a 4-entry FWFT FIFO instead of a single holding register.
//
// Parameters:
//   clk_freq_hz  system clock frequency in Hz
//   baud_rate    line rate; DIV = clk_freq_hz / baud_rate must be >= 4
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_uart_rx    asynchronous serial input, idle high
//   o_data       received byte (meaningful while o_valid)
//   o_valid      a byte is available
//   i_ready      consumer pops on o_valid && i_ready
//   o_overrun    sticky: a completed byte was dropped (storage full)
//   o_frame_err  sticky: a stop bit was sampled low
//   i_clear      pulse clearing both sticky flags (a same-cycle set wins)
module receiver_uart #(
    parameter int clk_freq_hz = 25000000,
    parameter int baud_rate   = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_overrun,
    output logic       o_frame_err,
    input  logic       i_clear
);

    localparam int DIV  = clk_freq_hz / baud_rate;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // Two-flop synchronizer; resets to the idle line level.
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_uart_rx};
        end
    end

    assign rx_s = sync_q[1];

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push;
    logic          ferr_set;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d    = '0;
                    bitidx_d = '0;
                    // A start bit that is gone by mid-bit is a glitch.
                    state_d  = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d            = '0;
                    shreg_d[bitidx_q] = rx_s;
                    bitidx_d         = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Break or bad frame: wait for the line to
                        // recover so a held low is a single error.
                        ferr_set = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic pop;
    logic full;
    logic wr_en;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [2:0] fill_q;

    assign full  = (fill_q == 3'd4);
    assign pop   = (fill_q != 3'd0) && i_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= shreg_q;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
            fill_q <= fill_q + {2'b00, wr_en} - {2'b00, pop};
        end
    end

    assign o_data  = mem_q[rd_q];
    assign o_valid = (fill_q != 3'd0);
`else
    logic [7:0] hold_q;
    logic       valid_q;

    assign full  = valid_q;
    assign pop   = valid_q && i_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr_en) begin
            hold_q  <= shreg_q;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign o_data  = hold_q;
    assign o_valid = valid_q;
`endif

    logic ovr_set;
    logic ovr_q;
    logic ferr_q;

    assign ovr_set = push && full && !pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_set || (ovr_q && !i_clear);
            ferr_q <= ferr_set || (ferr_q && !i_clear);
        end
    end

    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_receiver_uart.sv
// tb_receiver_uart: directed bench for receiver_uart with a queue-based
// reference model checked every cycle, plus literal spot checks.
module tb_receiver_uart;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    // DIV = 16, HALF = 8; a frame started after edge c pushes at c+155
    localparam int PUSH_OFS = 155;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ovr;
    logic       ferr;

    always #5 clk = ~clk;

    receiver_uart #(
        .clk_freq_hz(16),
        .baud_rate  (1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_uart_rx  (rx),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_overrun  (ovr),
        .o_frame_err(ferr),
        .i_clear    (clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: scheduled line events per edge
    // (byte value, or -1 for a failed stop bit).
    int         cyc = 0;
    int         sched [int];
    logic [7:0] mq [$];
    bit         m_ovr = 0;
    bit         m_ferr = 0;
    bit         m_pop, m_ok, m_ovs, m_fes;
    int         m_v;

    // Observation helpers
    logic [7:0] got [$];
    bit         pv = 0;
    logic [7:0] pd = 0;
    int         hi_cnt = 0;
    int         first_hi = -1;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (pv && ready && !rst) got.push_back(pd);
            if (rst) begin
                mq.delete();
                m_ovr  = 0;
                m_ferr = 0;
            end else begin
                m_pop = (mq.size() != 0) && ready;
                m_ok  = 0;
                m_ovs = 0;
                m_fes = 0;
                if (sched.exists(cyc)) begin
                    m_v = sched[cyc];
                    if (m_v < 0) m_fes = 1;
                    else if (mq.size() < DEPTH || m_pop) m_ok = 1;
                    else m_ovs = 1;
                end
                if (m_pop) void'(mq.pop_front());
                if (m_ok) mq.push_back(m_v[7:0]);
                m_ovr  = m_ovs || (m_ovr && !clr);
                m_ferr = m_fes || (m_ferr && !clr);
            end
            #1;
            chk("valid", valid, mq.size() != 0);
            if (mq.size() != 0) chk("data", data, mq[0]);
            chk("overrun", ovr, m_ovr);
            chk("frame_err", ferr, m_ferr);
            if (valid) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = cyc;
            end
            pv = valid;
            pd = data;
        end
    end

    // Drive one frame starting at the current negedge.
    task automatic send(input logic [7:0] b, input bit stop_ok,
                        input bit pop_at_push, output int c);
        logic [9:0] fr;
        c  = cyc;
        fr = {stop_ok, b, 1'b0};
        sched[c + PUSH_OFS] = stop_ok ? int'(b) : -1;
        for (int k = 0; k < 160; k++) begin
            rx = fr[k / 16];
            if (pop_at_push) ready = (k == PUSH_OFS - 1);
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int         c;
    logic [7:0] b;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_ferr", ferr, 0);
        repeat (5) @(negedge clk);

        // Single byte with ready held high
        ready    = 1'b1;
        hi_cnt   = 0;
        first_hi = -1;
        got.delete();
        send(8'hA5, 1, 0, c);
        repeat (10) @(negedge clk);
        chk("a5_rise_cyc", first_hi, c + 155);
        chk("a5_hi_cnt", hi_cnt, 1);
        chk("a5_cnt", got.size(), 1);
        if (got.size() > 0) chk("a5_byte", got[0], 8'hA5);

        // Start-bit glitch
        hi_cnt = 0;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_hi", hi_cnt, 0);
        chk("glitch_ferr", ferr, 0);

        // Bad stop bit, held break, then a good byte
        got.delete();
        send(8'h3C, 0, 0, c);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h81, 1, 0, c);
        repeat (10) @(negedge clk);
        chk("brk_ferr", ferr, 1);
        chk("brk_cnt", got.size(), 1);
        if (got.size() > 0) chk("brk_byte", got[0], 8'h81);

        // Overrun: DEPTH+1 bytes with nobody reading
        ready = 1'b0;
        got.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            b = (DEPTH == 1) ? 8'(8'h11 * (i + 1)) : 8'(i + 1);
            send(b, 1, 0, c);
        end
        repeat (5) @(negedge clk);
        chk("ovr_flag", ovr, 1);
        chk("ovr_head", data, (DEPTH == 1) ? 8'h11 : 8'h01);
        ready = 1'b1;
        repeat (DEPTH + 3) @(negedge clk);
        ready = 1'b0;
        chk("ovr_cnt", got.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            b = (DEPTH == 1) ? 8'(8'h11 * (i + 1)) : 8'(i + 1);
            chk("ovr_byte", got[i], b);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_ovr", ovr, 0);
        chk("clr_ferr", ferr, 0);

        // Full storage, pop on the very edge of the next push
        got.delete();
        for (int i = 0; i < DEPTH; i++) begin
            send(8'(8'h40 + i), 1, 0, c);
        end
        send(8'h99, 1, 1, c);
        repeat (3) @(negedge clk);
        chk("pp_ovr", ovr, 0);
        ready = 1'b1;
        repeat (DEPTH + 3) @(negedge clk);
        ready = 1'b0;
        chk("pp_cnt", got.size(), DEPTH + 1);
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            chk("pp_byte", got[i], 8'(8'h40 + i));
        end
        if (got.size() > DEPTH) chk("pp_last", got[DEPTH], 8'h99);

        // Reset during data bit 3 of 0xF8, then 0x5A
        send(8'h77, 1, 0, c);
        repeat (3) @(negedge clk);
        got.delete();
        c  = cyc;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", valid, 0);
        chk("mrst_data", data, 0);
        chk("mrst_ovr", ovr, 0);
        chk("mrst_ferr", ferr, 0);
        repeat (120) @(negedge clk);
        ready = 1'b1;
        send(8'h5A, 1, 0, c);
        repeat (10) @(negedge clk);
        chk("mrst_cnt", got.size(), 1);
        if (got.size() > 0) chk("mrst_byte", got[0], 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
